// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH-bit, DEPTH-stage registered delay line with per-stage valid, stall, flush and occupancy
// Ports: clk/rst (sync, active-high); en advances the pipe; flush clears it like reset;
//        din/din_vld enter stage 0; dout/dout_vld are the last stage; occ counts valid stages; busy = occ != 0
module dff_pipe #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         flush,
   input  logic                         din_vld,
   input  logic [WIDTH-1:0]             din,
   output logic                         dout_vld,
   output logic [WIDTH-1:0]             dout,
   output logic [$clog2(DEPTH+1)-1:0]   occ,
   output logic                         busy
);
   localparam int OW = $clog2(DEPTH+1);
   logic [WIDTH-1:0] data [DEPTH];
   logic [DEPTH-1:0] vld;
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int i = 0; i < DEPTH; i++) data[i] <= RST_VAL;
         vld <= '0;
         occ <= '0;
      end else if (en) begin
         data[0] <= din;
         vld[0]  <= din_vld;
         for (int i = 1; i < DEPTH; i++) begin
            data[i] <= data[i-1];
            vld[i]  <= vld[i-1];
         end
         // entry and exit share the edge, so the count never leaves 0..DEPTH
         occ <= occ + OW'(din_vld) - OW'(vld[DEPTH-1]);
      end
   end
   assign dout     = data[DEPTH-1];
   assign dout_vld = vld[DEPTH-1];
   assign busy     = occ != '0;
endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: checks a DEPTH=4 and a DEPTH=1 dff_pipe against a queue model of the stages
module tb_dff_pipe;
   logic clk = 1'b0, rst = 1'b0, en = 1'b0, flush = 1'b0, din_vld = 1'b0;
   logic [7:0] din = '0;
   logic dout_vld4, busy4, dout_vld1, busy1;
   logic [7:0] dout4, dout1;
   logic [2:0] occ4;
   logic [0:0] occ1;
   int n_vec = 0, n_err = 0;
   logic [8:0] m4[$];
   logic [8:0] m1[$];
   always #5 clk = ~clk;
   dff_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h00)) u4 (
      .clk(clk), .rst(rst), .en(en), .flush(flush), .din_vld(din_vld), .din(din),
      .dout_vld(dout_vld4), .dout(dout4), .occ(occ4), .busy(busy4));
   dff_pipe #(.WIDTH(8), .DEPTH(1), .RST_VAL(8'h00)) u1 (
      .clk(clk), .rst(rst), .en(en), .flush(flush), .din_vld(din_vld), .din(din),
      .dout_vld(dout_vld1), .dout(dout1), .occ(occ1), .busy(busy1));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask
   task automatic step(input logic e, input logic f, input logic r, input logic v, input logic [7:0] d);
      int c4, c1;
      en = e; flush = f; rst = r; din_vld = v; din = d;
      @(posedge clk);
      if (r || f) begin
         m4.delete(); m1.delete();
         repeat (4) m4.push_back(9'h000);
         m1.push_back(9'h000);
      end else if (e) begin
         m4.push_front({v, d}); void'(m4.pop_back());
         m1.push_front({v, d}); void'(m1.pop_back());
      end
      c4 = 0;
      foreach (m4[i]) c4 += int'(m4[i][8]);
      c1 = int'(m1[0][8]);
      #1;
      chk("d4_dout", 32'(dout4), 32'(m4[3][7:0]));
      chk("d4_dout_vld", 32'(dout_vld4), 32'(m4[3][8]));
      chk("d4_occ", 32'(occ4), 32'(c4));
      chk("d4_busy", 32'(busy4), 32'(c4 != 0));
      chk("d1_dout", 32'(dout1), 32'(m1[0][7:0]));
      chk("d1_dout_vld", 32'(dout_vld1), 32'(m1[0][8]));
      chk("d1_occ", 32'(occ1), 32'(c1));
      chk("d1_busy", 32'(busy1), 32'(c1 != 0));
   endtask
   initial begin
      // reset held 2 cycles with live inputs, then one idle cycle
      step(1, 0, 1, 1, 8'hA5);
      step(1, 0, 1, 1, 8'hA5);
      step(0, 0, 0, 0, 8'hA5);
      // full-throughput stream 1..10, drained
      for (int i = 1; i <= 10; i++) step(1, 0, 0, 1, 8'(i));
      repeat (5) step(1, 0, 0, 0, 8'h00);
      // stall for 3 cycles after word 5
      for (int i = 1; i <= 10; i++) begin
         step(1, 0, 0, 1, 8'(i));
         if (i == 5) repeat (3) step(0, 0, 0, 1, 8'hEE);
      end
      repeat (5) step(1, 0, 0, 0, 8'h00);
      // bubbles
      step(1, 0, 0, 1, 8'd11);
      step(1, 0, 0, 0, 8'd22);
      step(1, 0, 0, 1, 8'd33);
      step(1, 0, 0, 0, 8'd44);
      repeat (5) step(1, 0, 0, 0, 8'h00);
      // flush mid-stream discards the word presented with it
      for (int i = 1; i <= 3; i++) step(1, 0, 0, 1, 8'(8'h30 + i));
      step(1, 1, 0, 1, 8'h77);
      step(1, 0, 0, 1, 8'h41);
      repeat (4) step(1, 0, 0, 0, 8'h00);
      // flush and reset together
      step(1, 0, 0, 1, 8'h55);
      step(1, 1, 1, 1, 8'h66);
      // alternate en and din_vld (exercises DEPTH=1 toggling)
      for (int i = 0; i < 12; i++) step(logic'(i % 2 == 0), 0, 0, logic'((i / 2) % 2 == 0), 8'(8'h80 + i));
      // randomized traffic
      for (int i = 0; i < 400; i++)
         step(logic'($urandom_range(3) != 0), logic'($urandom_range(24) == 0),
              logic'($urandom_range(60) == 0), logic'($urandom_range(1)), 8'($urandom));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/dff_pipe.md
# dff_pipe

Parametrised successor to the single-bit `dff` DUT: a `WIDTH`-bit, `DEPTH`-stage registered delay line with per-stage valid tracking, stall (`en`), synchronous flush and an occupancy count. It is the next DUT under the `dff_top` style bench. The matching driver extends `drv_dff` to drive `din`/`din_vld`/`en`/`flush` and sample `dout`/`dout_vld`/`occ` through `s2cif`.

## Interface
- `WIDTH`, 8: data width in bits, ≥1.
- `DEPTH`, 4: number of register stages, ≥1.
- `RST_VAL`, '0: value loaded into every data stage on reset and flush (`WIDTH` bits).
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  advance: pipeline shifts by one stage when high.
- `flush`  in  1  synchronous clear of all valid bits and data.
- `din_vld`  in  1  qualifies `din` for capture.
- `din`  in  `WIDTH`  input data.
- `dout_vld`  out  1  valid bit of the last stage.
- `dout`  out  `WIDTH`  data of the last stage, registered.
- `occ`  out  `$clog2(DEPTH+1)`  number of stages whose valid bit is set, registered.
- `busy`  out  1  `occ != 0`, combinational from `occ`.

## Operation
- State: `data[0..DEPTH-1]` (`WIDTH` bits each), `vld[0..DEPTH-1]`, `occ`. `dout = data[DEPTH-1]`, `dout_vld = vld[DEPTH-1]`.
- Priority per edge: `rst` > `flush` > `en` > hold.
- `rst`: all `data` = `RST_VAL`, all `vld` = 0, `occ` = 0. Outputs after reset: `dout` = `RST_VAL`, `dout_vld` = 0, `occ` = 0, `busy` = 0.
- `flush` (no `rst`): identical effect to reset. `din` is discarded even if `en` and `din_vld` are high.
- `en` (no `rst`/`flush`):
  - `data[0] <= din`, `vld[0] <= din_vld`.
  - `data[i] <= data[i-1]`, `vld[i] <= vld[i-1]` for i = 1..DEPTH-1.
  - The last stage's contents leave the pipe.
  - `occ <= occ + din_vld - vld[DEPTH-1]`.
- Hold (`en` = 0): all state unchanged, including `occ`. `din`/`din_vld` are ignored.
- Bubbles: data in stages with `vld` = 0 shifts unchanged. `dout` is meaningful only when `dout_vld` = 1, but its value is still deterministic: whatever was shifted in.
- `occ` is maintained incrementally and must always equal popcount(`vld`). Range is 0..DEPTH. No overflow is possible, because entry and exit happen on the same edge.
- `DEPTH` = 1: single stage. `occ` width is 1; behaviour follows the same rules.

## Timing
- Latency: a word captured at edge N with `en` = 1 appears on `dout` after edge N+DEPTH−1 of the subsequent `en`-high edges. It is therefore visible on `dout` after exactly DEPTH `en`-high edges in total, counting its capture edge.
- Full throughput: with `en` held high, one word in and one word out per cycle.
- Stall cycles (`en` = 0) add latency one-for-one and never lose or duplicate data.
- `flush` or `rst` asserted mid-stream: on the following cycle `dout_vld` = 0 and `occ` = 0. The first word captured afterwards appears after DEPTH `en` edges.
- `flush` and `rst` together: reset behaviour (identical result).
- No combinational path from inputs to `dout`, `dout_vld` or `occ`. `busy` depends on `occ` only.

## Test plan
- Reset: hold `rst` for 2 cycles with `en` = 1, `din_vld` = 1, `din` = 8'hA5. Required: `dout` = 8'h00, `dout_vld` = 0, `occ` = 0, `busy` = 0 throughout, and 1 cycle after release still `occ` = 0 until the first captured edge.
- Latency/throughput (WIDTH=8, DEPTH=4): `en` = 1, stream `din` = 1,2,3…10 with `din_vld` = 1. Required: `dout` = 1 with `dout_vld` = 1 on the cycle after the 4th edge, then 2..10 on consecutive cycles; `occ` ramps 1,2,3,4 and stays at 4.
- Stall: as the previous scenario, but drop `en` for 3 cycles after word 5 is captured. Required: `dout`, `dout_vld` and `occ` frozen for those 3 cycles; the output sequence remains 1..10 with no gaps or repeats, delayed by 3 cycles.
- Bubbles: `din_vld` pattern 1,0,1,0 with `din` = 11,22,33,44. Required: `dout_vld` pattern 1,0,1,0 with `dout` = 11,22,33,44 DEPTH edges later; `occ` peaks at 2.
- Flush mid-stream: after 3 valid words, assert `flush` together with `en` = 1, `din_vld` = 1, `din` = 8'h77. Required: next cycle `occ` = 0, `dout_vld` = 0, `dout` = `RST_VAL`; 8'h77 never appears; the next valid word emerges after 4 edges.
- DEPTH=1 variant: alternate `en` and `din_vld`. Required: `dout` follows `din` one `en` edge later; `occ` toggles 0/1 and equals `dout_vld`.
